matmul_result_checker: RTL and testbench

Synthesizable, parametrised successor to the matmul golden checker. It takes an expected N x M result matrix through a valid/ready load port and stores it internally. It then captures the row-major result stream of the matmul DUT and compares each element against the stored value, either exactly or within a runtime absolute tolerance. It reports an error count, the first mismatch, a pass/fail verdict and a batch count, so the check runs in emulation/FPGA as well as simulation.

---
 rtl/matmul_result_checker_if.sv | 50 +++++
 rtl/matmul_result_checker.sv | 178 +++++++++++++++++
 tb/tb_matmul_result_checker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_result_checker_if.sv
// Purpose: bundles the load, control, result and status signals of the matmul result checker.
// Latency: none, this is wiring only.
// Backpressure: only the expected-matrix load port has a ready; the result stream cannot be stalled.
//
// slave modport  : the checker (receives load/control/result, drives status)
// master modport : the environment driving the checker
interface matmul_result_checker_if #(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TOL_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int IDX_W = (N * M > 1) ? $clog2(N * M) : 1;

    // expected-matrix load port
    logic                  exp_valid_i;
    logic [DATA_WIDTH-1:0] exp_data_i;
    logic                  exp_ready_o;
    // control
    logic                  clear_i;
    logic                  start_i;
    // result stream from the matmul under test
    logic                  res_valid_i;
    logic [DATA_WIDTH-1:0] res_data_i;
    logic [TOL_WIDTH-1:0]  tol_i;
    // status
    logic                  busy_o;
    logic                  done_o;
    logic                  pass_o;
    logic [CNT_WIDTH-1:0]  err_cnt_o;
    logic                  first_err_valid_o;
    logic [IDX_W-1:0]      first_err_idx_o;
    logic [DATA_WIDTH-1:0] first_err_exp_o;
    logic [DATA_WIDTH-1:0] first_err_got_o;
    logic                  overflow_o;
    logic [CNT_WIDTH-1:0]  batch_cnt_o;

    modport slave (
        input  exp_valid_i, exp_data_i, clear_i, start_i, res_valid_i, res_data_i, tol_i,
        output exp_ready_o, busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o,
               first_err_idx_o, first_err_exp_o, first_err_got_o, overflow_o, batch_cnt_o
    );

    modport master (
        output exp_valid_i, exp_data_i, clear_i, start_i, res_valid_i, res_data_i, tol_i,
        input  exp_ready_o, busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o,
               first_err_idx_o, first_err_exp_o, first_err_got_o, overflow_o, batch_cnt_o
    );
endinterface

// File: rtl/matmul_result_checker.sv
// Purpose: stores an expected N x M matrix, then compares a row-major result stream against it (exact or +/- tol).
// Latency: error count / first-error update 1 cycle after a sample; done 2 cycles after the last sample.
// Backpressure: exp_ready_o only in IDLE/LOAD; result stream is never stalled, extra samples in DONE flag overflow.
//
// Ports: clk, rst_n (async active-low) plus bus (slave modport) carrying load port, clear/start,
//        result stream with tolerance, and the verdict/status outputs.
module matmul_result_checker #(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int DATA_WIDTH = 16,
    parameter bit SIGNED     = 1'b1,
    parameter int TOL_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matmul_result_checker_if.slave  bus
);
    localparam int DEPTH  = N * M;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIFF_W = DATA_WIDTH + 1;
    localparam int CMP_W  = (DIFF_W > TOL_WIDTH) ? DIFF_W : TOL_WIDTH;
    localparam logic [IDX_W-1:0]     LAST    = IDX_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, CHECK, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      ld_ptr;
    logic [IDX_W-1:0]      idx;
    // High for the one cycle between the last sample and DONE, while its error update settles.
    logic                  drain;

    logic [CNT_WIDTH-1:0]  err_cnt;
    logic                  first_err_valid;
    logic [IDX_W-1:0]      first_err_idx;
    logic [DATA_WIDTH-1:0] first_err_exp;
    logic [DATA_WIDTH-1:0] first_err_got;
    logic                  overflow;
    logic [CNT_WIDTH-1:0]  batch_cnt;

    logic exp_ready, busy, done;
    logic exp_acc, res_acc, pass_clr;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        exp_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                exp_ready = 1'b1;
                if (bus.exp_valid_i) state_nxt = (DEPTH == 1) ? ARMED : LOAD;
            end
            LOAD: begin
                exp_ready = 1'b1;
                if (bus.exp_valid_i && ld_ptr == LAST) state_nxt = ARMED;
            end
            ARMED: begin
                if (bus.start_i) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (drain) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start_i) state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.clear_i) state_nxt = IDLE;
    end

    assign exp_acc  = exp_ready & bus.exp_valid_i;
    assign res_acc  = (state == CHECK) & ~drain & bus.res_valid_i;
    assign pass_clr = bus.start_i & ((state == ARMED) | (state == DONE));

    // ---------------------------------------------------------------- compare
    // Both operands are widened by one bit so the difference never overflows;
    // for unsigned data the widened difference is still a valid signed value.
    logic [DATA_WIDTH-1:0] exp_val;
    logic [DIFF_W-1:0]     exp_ext, got_ext, diff, abs_diff;
    logic                  mismatch;

    always_comb begin
        exp_val  = mem[idx];
        exp_ext  = SIGNED ? {exp_val[DATA_WIDTH-1], exp_val} : {1'b0, exp_val};
        got_ext  = SIGNED ? {bus.res_data_i[DATA_WIDTH-1], bus.res_data_i} : {1'b0, bus.res_data_i};
        diff     = got_ext - exp_ext;
        abs_diff = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
        mismatch = CMP_W'(abs_diff) > CMP_W'(bus.tol_i);
    end

    // ---------------------------------------------------------------- storage
    // No reset: contents are meaningless until a full load completes.
    always_ff @(posedge clk) begin
        if (exp_acc && !bus.clear_i) mem[ld_ptr] <= bus.exp_data_i;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ptr          <= '0;
            idx             <= '0;
            drain           <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            overflow        <= 1'b0;
            batch_cnt       <= '0;
        end else if (bus.clear_i) begin
            ld_ptr          <= '0;
            idx             <= '0;
            drain           <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            overflow        <= 1'b0;
            batch_cnt       <= '0;
        end else begin
            if (exp_acc) ld_ptr <= (ld_ptr == LAST) ? '0 : ld_ptr + IDX_W'(1);

            if (pass_clr) begin
                idx             <= '0;
                drain           <= 1'b0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
                overflow        <= 1'b0;
            end else begin
                drain <= res_acc && (idx == LAST);
                if (res_acc) begin
                    idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
                    if (mismatch) begin
                        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_WIDTH'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= idx;
                            first_err_exp   <= exp_val;
                            first_err_got   <= bus.res_data_i;
                        end
                    end
                end
                // drain is exactly the cycle that enters DONE
                if (drain && batch_cnt != CNT_MAX) batch_cnt <= batch_cnt + CNT_WIDTH'(1);
                if (state == DONE && bus.res_valid_i) overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.exp_ready_o       = exp_ready;
    assign bus.busy_o            = busy;
    assign bus.done_o            = done;
    assign bus.pass_o            = done & (err_cnt == '0) & ~overflow;
    assign bus.err_cnt_o         = err_cnt;
    assign bus.first_err_valid_o = first_err_valid;
    assign bus.first_err_idx_o   = first_err_idx;
    assign bus.first_err_exp_o   = first_err_exp;
    assign bus.first_err_got_o   = first_err_got;
    assign bus.overflow_o        = overflow;
    assign bus.batch_cnt_o       = batch_cnt;
endmodule

// File: tb/tb_matmul_result_checker.sv
// Bench for matmul_result_checker: a signed and an unsigned 2x2, 8-bit instance share one stimulus stream.
module tb_matmul_result_checker;
    localparam int N = 2, M = 2, DW = 8, TW = 8, CW = 16, DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          exp_valid, clear, start, res_valid;
    logic [DW-1:0] exp_data, res_data;
    logic [TW-1:0] tol;

    matmul_result_checker_if #(.N(N), .M(M), .DATA_WIDTH(DW), .TOL_WIDTH(TW), .CNT_WIDTH(CW)) if_s ();
    matmul_result_checker_if #(.N(N), .M(M), .DATA_WIDTH(DW), .TOL_WIDTH(TW), .CNT_WIDTH(CW)) if_u ();

    assign if_s.exp_valid_i = exp_valid;  assign if_u.exp_valid_i = exp_valid;
    assign if_s.exp_data_i  = exp_data;   assign if_u.exp_data_i  = exp_data;
    assign if_s.clear_i     = clear;      assign if_u.clear_i     = clear;
    assign if_s.start_i     = start;      assign if_u.start_i     = start;
    assign if_s.res_valid_i = res_valid;  assign if_u.res_valid_i = res_valid;
    assign if_s.res_data_i  = res_data;   assign if_u.res_data_i  = res_data;
    assign if_s.tol_i       = tol;        assign if_u.tol_i       = tol;

    matmul_result_checker #(.N(N), .M(M), .DATA_WIDTH(DW), .SIGNED(1'b1), .TOL_WIDTH(TW), .CNT_WIDTH(CW))
        u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    matmul_result_checker #(.N(N), .M(M), .DATA_WIDTH(DW), .SIGNED(1'b0), .TOL_WIDTH(TW), .CNT_WIDTH(CW))
        u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] s_got [DEPTH];
    int            s_tol [DEPTH];
    int            m_batch = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sval(input bit sg, input logic [DW-1:0] v);
        return sg ? int'($signed(v)) : int'(v);
    endfunction

    function automatic bit mis(input bit sg, input logic [DW-1:0] e, input logic [DW-1:0] g, input int t);
        int d;
        d = sval(sg, g) - sval(sg, e);
        if (d < 0) d = -d;
        return d > t;
    endfunction

    // status of a freshly reset / cleared checker
    task automatic chk_idle(input string tag);
        for (int s = 0; s < 2; s++) begin
            string p;
            p = $sformatf("%s%s", tag, (s == 1) ? "_s" : "_u");
            chk({p, ".ready"}, 32'((s == 1) ? if_s.exp_ready_o : if_u.exp_ready_o), 32'd1);
            chk({p, ".busy"},  32'((s == 1) ? if_s.busy_o : if_u.busy_o), 32'd0);
            chk({p, ".done"},  32'((s == 1) ? if_s.done_o : if_u.done_o), 32'd0);
            chk({p, ".pass"},  32'((s == 1) ? if_s.pass_o : if_u.pass_o), 32'd0);
            chk({p, ".err"},   32'((s == 1) ? if_s.err_cnt_o : if_u.err_cnt_o), 32'd0);
            chk({p, ".fev"},   32'((s == 1) ? if_s.first_err_valid_o : if_u.first_err_valid_o), 32'd0);
            chk({p, ".fexp"},  32'((s == 1) ? if_s.first_err_exp_o : if_u.first_err_exp_o), 32'd0);
            chk({p, ".ovf"},   32'((s == 1) ? if_s.overflow_o : if_u.overflow_o), 32'd0);
            chk({p, ".batch"}, 32'((s == 1) ? if_s.batch_cnt_o : if_u.batch_cnt_o), 32'd0);
        end
    endtask

    // verdict after a completed pass, both instances against the model
    task automatic check_result(input string tag, input bit ovf);
        for (int s = 0; s < 2; s++) begin
            bit    sg;
            int    errs, fi, fc;
            string p;
            sg   = (s == 1);
            errs = 0;
            fi   = -1;
            p    = $sformatf("%s%s", tag, sg ? "_s" : "_u");
            for (int i = 0; i < DEPTH; i++)
                if (mis(sg, m_mem[i], s_got[i], s_tol[i])) begin
                    errs++;
                    if (fi < 0) fi = i;
                end
            fc = (fi < 0) ? 0 : fi;
            chk({p, ".err"},   32'(sg ? if_s.err_cnt_o : if_u.err_cnt_o), 32'(errs));
            chk({p, ".fev"},   32'(sg ? if_s.first_err_valid_o : if_u.first_err_valid_o), 32'(fi >= 0));
            chk({p, ".fidx"},  32'(sg ? if_s.first_err_idx_o : if_u.first_err_idx_o), 32'(fc));
            chk({p, ".fexp"},  32'(sg ? if_s.first_err_exp_o : if_u.first_err_exp_o),
                (fi >= 0) ? 32'(m_mem[fc]) : 32'd0);
            chk({p, ".fgot"},  32'(sg ? if_s.first_err_got_o : if_u.first_err_got_o),
                (fi >= 0) ? 32'(s_got[fc]) : 32'd0);
            chk({p, ".done"},  32'(sg ? if_s.done_o : if_u.done_o), 32'd1);
            chk({p, ".busy"},  32'(sg ? if_s.busy_o : if_u.busy_o), 32'd0);
            chk({p, ".pass"},  32'(sg ? if_s.pass_o : if_u.pass_o), 32'((errs == 0) && !ovf));
            chk({p, ".ovf"},   32'(sg ? if_s.overflow_o : if_u.overflow_o), 32'(ovf));
            chk({p, ".batch"}, 32'(sg ? if_s.batch_cnt_o : if_u.batch_cnt_o), 32'(m_batch));
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic load_elems(input logic [DW-1:0] v [DEPTH], input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            exp_valid = 1'b1;
            exp_data  = v[i];
            @(negedge clk);
            exp_valid = 1'b0;
            m_mem[i]  = v[i];
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        m_batch = 0;
    endtask

    task automatic stream(input string tag, input logic [DW-1:0] g [DEPTH], input int t [DEPTH], input bit gaps);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            res_valid = 1'b1;
            res_data  = g[i];
            tol       = TW'(t[i]);
            s_got[i]  = g[i];
            s_tol[i]  = t[i];
            @(negedge clk);
            res_valid = 1'b0;
        end
        // one cycle after the last sample: still busy, not yet done
        chk({tag, ".drain_done"}, 32'(if_s.done_o | if_u.done_o), 32'd0);
        chk({tag, ".drain_busy"}, 32'(if_s.busy_o & if_u.busy_o), 32'd1);
        @(negedge clk);
        m_batch++;
        check_result(tag, 1'b0);
    endtask

    logic [DW-1:0] v_a [DEPTH], v_b [DEPTH], v_s [DEPTH], v_g [DEPTH], v_w [DEPTH];
    int t0 [DEPTH], t1 [DEPTH], t2 [DEPTH], tr [DEPTH];

    initial begin
        rst_n = 1'b0; exp_valid = 1'b0; exp_data = '0; clear = 1'b0; start = 1'b0;
        res_valid = 1'b0; res_data = '0; tol = '0;
        v_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        v_b = '{8'd1, 8'd9, 8'd3, 8'd7};
        v_s = '{8'hFB, 8'h00, 8'h7F, 8'h80};   // -5, 0, 127, -128
        v_g = '{8'hFD, 8'h02, 8'h7D, 8'h82};   // -3, 2, 125, -126
        v_w = '{8'hFB, 8'h00, 8'h80, 8'h7F};   // swaps 127/-128: far apart signed, adjacent unsigned
        t0 = '{0, 0, 0, 0};
        t1 = '{1, 1, 1, 1};
        t2 = '{2, 2, 2, 2};

        // reset
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // exact match, then two mismatches
        load_elems(v_a, 0, DEPTH - 1, 1'b0);
        chk("armed.ready", 32'(if_s.exp_ready_o | if_u.exp_ready_o), 32'd0);
        pulse_start();
        stream("match", v_a, t0, 1'b0);
        pulse_start();
        stream("mism", v_b, t0, 1'b0);

        // clear drops everything including batch count
        pulse_clear();
        chk_idle("clear1");

        // gapped load with an ignored start in the middle
        load_elems(v_s, 0, 1, 1'b1);
        pulse_start();
        chk("ld_start.busy",  32'(if_s.busy_o | if_u.busy_o), 32'd0);
        chk("ld_start.ready", 32'(if_s.exp_ready_o & if_u.exp_ready_o), 32'd1);
        load_elems(v_s, 2, DEPTH - 1, 1'b1);
        chk("loaded.ready", 32'(if_s.exp_ready_o | if_u.exp_ready_o), 32'd0);
        chk("loaded.busy",  32'(if_s.busy_o | if_u.busy_o), 32'd0);
        chk("loaded.done",  32'(if_s.done_o | if_u.done_o), 32'd0);
        // extra load traffic while armed must not touch memory
        exp_valid = 1'b1;
        exp_data  = 8'h55;
        @(negedge clk);
        chk("armed_extra.ready", 32'(if_s.exp_ready_o | if_u.exp_ready_o), 32'd0);
        @(negedge clk);
        exp_valid = 1'b0;

        pulse_start();
        stream("tol2", v_g, t2, 1'b0);
        pulse_start();
        stream("tol1", v_g, t1, 1'b1);
        pulse_start();
        stream("wrap", v_w, t1, 1'b0);

        // overflow in DONE, then a clean re-run clears it
        res_valid = 1'b1;
        res_data  = 8'h11;
        @(negedge clk);
        res_valid = 1'b0;
        check_result("ovf", 1'b1);
        pulse_start();
        stream("rerun", v_s, t0, 1'b0);

        // randomised passes against fresh matrices
        for (int r = 0; r < 8; r++) begin
            logic [DW-1:0] vm [DEPTH];
            logic [DW-1:0] vg [DEPTH];
            pulse_clear();
            for (int i = 0; i < DEPTH; i++) begin
                vm[i] = DW'($urandom);
                vg[i] = (r % 3 == 2) ? DW'($urandom) : vm[i] + DW'($urandom_range(0, 6)) - DW'(3);
                tr[i] = $urandom_range(0, 3);
            end
            load_elems(vm, 0, DEPTH - 1, 1'b1);
            pulse_start();
            stream($sformatf("rnd%0d", r), vg, tr, 1'b1);
            if (r % 2 == 1) begin
                pulse_start();
                stream($sformatf("rnd%0d_re", r), vg, tr, 1'b0);
            end
        end

        // asynchronous reset after two samples of a pass
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            res_valid = 1'b1;
            res_data  = m_mem[i] + 8'd1;
            @(negedge clk);
        end
        res_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        m_batch = 0;
        chk_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_elems(v_a, 0, DEPTH - 1, 1'b0);
        pulse_start();
        stream("after_rst", v_a, t0, 1'b0);

        // clear from DONE
        pulse_clear();
        chk_idle("clear2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
